// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_port_arbiter: shares one OBI-style memory port between I-side and D-side
// requesters, with in-order source-ID tracking for response routing.
// Revision: 1.0
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic        i_gnt_o,
  output logic [31:0] i_rdata_o,
  output logic        i_rvalid_o,
  output logic        i_err_o,
  input  logic        d_req_i,
  input  logic [31:0] d_addr_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic [31:0] d_rdata_o,
  output logic        d_rvalid_o,
  output logic        d_err_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_rvalid_i,
  input  logic        mem_err_i,
  output logic [2:0]  outstanding_o,
  output logic        protocol_err_o
);

  localparam int c_sw = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_ids;
  logic [1:0]      r_wptr, r_rptr;
  logic [2:0]      r_count;
  logic [c_sw-1:0] r_starve;
  logic            r_perr;

  logic w_sel_i, w_sel_d, w_full, w_push, w_pop, w_head_d, w_gnt_i, w_gnt_d;

  function automatic logic [1:0] f_wrap(input logic [1:0] ptr);
    return (ptr == 2'(MAX_OUTSTANDING - 1)) ? 2'd0 : ptr + 2'd1;
  endfunction

  // A simultaneous pop frees an entry, so a full FIFO may still accept a push.
  assign w_full = (r_count == 3'(MAX_OUTSTANDING)) & ~mem_rvalid_i;

  always_comb begin
    w_sel_i     = 1'b0;
    w_sel_d     = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      LOCK_I: begin
        w_sel_i = 1'b1;
        if (mem_gnt_i) w_state_nxt = IDLE;
      end
      LOCK_D: begin
        w_sel_d = 1'b1;
        if (mem_gnt_i) w_state_nxt = IDLE;
      end
      default: begin
        if (!w_full) begin
          if ((r_starve == c_sw'(STARVE_LIMIT)) && i_req_i) w_sel_i = 1'b1;
          else if (d_req_i)                                 w_sel_d = 1'b1;
          else if (i_req_i)                                 w_sel_i = 1'b1;
        end
        if (w_sel_i && !mem_gnt_i)      w_state_nxt = LOCK_I;
        else if (w_sel_d && !mem_gnt_i) w_state_nxt = LOCK_D;
      end
    endcase
  end

  assign w_gnt_i  = w_sel_i & mem_gnt_i;
  assign w_gnt_d  = w_sel_d & mem_gnt_i;
  assign w_push   = w_gnt_i | w_gnt_d;
  assign w_pop    = mem_rvalid_i & (r_count != 3'd0);
  assign w_head_d = r_ids[r_rptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_ids    <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_starve <= '0;
      r_perr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) begin
        r_ids[r_wptr] <= w_sel_d;
        r_wptr        <= f_wrap(r_wptr);
      end
      if (w_pop) r_rptr <= f_wrap(r_rptr);
      r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
      if (mem_rvalid_i && (r_count == 3'd0)) r_perr <= 1'b1;
      if (w_gnt_i || !i_req_i) begin
        r_starve <= '0;
      end else if ((w_gnt_d || (r_state == LOCK_D)) && (r_starve != c_sw'(STARVE_LIMIT))) begin
        r_starve <= r_starve + c_sw'(1);
      end
    end
  end

  assign mem_req_o   = w_sel_i | w_sel_d;
  assign mem_addr_o  = w_sel_d ? d_addr_i : (w_sel_i ? i_addr_i : 32'h0);
  assign mem_we_o    = w_sel_d & d_we_i;
  assign mem_be_o    = w_sel_d ? d_be_i : (w_sel_i ? 4'hF : 4'h0);
  assign mem_wdata_o = w_sel_d ? d_wdata_i : 32'h0;
  assign i_gnt_o     = w_gnt_i;
  assign d_gnt_o     = w_gnt_d;

  assign i_rvalid_o = w_pop & ~w_head_d;
  assign d_rvalid_o = w_pop & w_head_d;
  assign i_rdata_o  = i_rvalid_o ? mem_rdata_i : 32'h0;
  assign d_rdata_o  = d_rvalid_o ? mem_rdata_i : 32'h0;
  assign i_err_o    = i_rvalid_o & mem_err_i;
  assign d_err_o    = d_rvalid_o & mem_err_i;

  assign outstanding_o  = r_count;
  assign protocol_err_o = r_perr;

endmodule
`default_nettype wire
